hash_output_writer: RTL and testbench
=====================================

Name: hash_output_writer

Overview:
Drains a finished SHA-256 digest (eight 32-bit words H0..H7) into word-addressed memory, one word per accepted write. It is the write-back end of the datapath whose input side loads message words into registers. Memory applies backpressure through a ready/write-enable handshake. Completion is reported with a one-cycle pulse to the top-level controller.

Parameters:
DATA_WIDTH, 32, width of one memory word and of one digest word
NUM_WORDS, 8, number of digest words written per transaction
ADDR_WIDTH, 16, width of the memory word address

Ports:
clock  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to write the digest; sampled only in IDLE
base_address  input  ADDR_WIDTH  address for word 0; captured with start
digest  input  NUM_WORDS*DATA_WIDTH  H0 in the MSBs, H7 in the LSBs; captured with start
mem_ready  input  1  memory accepts the current write this cycle
mem_write_en  output  1  write request valid (registered)
mem_address  output  ADDR_WIDTH  write address (registered)
mem_write_data  output  DATA_WIDTH  write data (registered)
busy  output  1  high in the WRITE and DONE states
write_complete  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. mem_write_en, mem_address, mem_write_data, busy, write_complete and the word index all go to 0. The captured digest is cleared. Reset overrides every other input in the same cycle.
- States: IDLE, WRITE, DONE.
- IDLE, start=1 at edge t:
  - Capture digest into the internal shift/holding register and base_address into the address register.
  - Set word index to 0 and go to WRITE.
  - At t+1: mem_write_en=1, mem_address=base_address, mem_write_data=digest[255:224] (H0), busy=1.
- IDLE, start=0: all outputs stay 0.
- WRITE: a transfer happens at an edge where mem_write_en=1 and mem_ready=1.
  - Transfer of a word that is not the last: the next cycle shows the next word (H1..H7 in order), mem_address+1, and mem_write_en stays 1.
  - mem_ready=0: mem_write_en, mem_address and mem_write_data hold their values. The write request is never withdrawn once raised.
  - Transfer of word NUM_WORDS-1: the next cycle has mem_write_en=0, state DONE, write_complete=1, busy=1.
- DONE: lasts exactly one cycle, then goes to IDLE with busy=0 and write_complete=0.
- Latency with mem_ready held at 1:
  - start at edge t; words appear on cycles t+1..t+8.
  - write_complete=1 on cycle t+9.
  - IDLE on cycle t+10. The earliest next start is accepted at the t+10 edge.
- start while in WRITE or DONE is ignored. The digest and base_address inputs are not re-sampled, and an in-flight transaction is unaffected.
- Address arithmetic is modulo 2^ADDR_WIDTH. 0xFFFF+1 wraps to 0x0000 with no error flag.
- Digest input may change after the start cycle; output data comes only from the captured copy.
- Reset mid-WRITE aborts immediately. There are no further writes, and write_complete is not pulsed for the aborted transaction.
- mem_write_data and mem_address hold their last values when mem_write_en=0 after a transaction. They are defined only while mem_write_en=1.
- NUM_WORDS is ≥1. A word-index counter of ceil(log2(NUM_WORDS))+1 bits prevents overflow at the last word.

Test Plan:
1. Reset values: hold reset for 3 cycles with random inputs, including start=1 -> all outputs 0 and no write observed.
2. Continuous ready: base_address=0x0100, digest=0x6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, mem_ready=1, start pulse at edge t.
   - Writes 0x0100..0x0107 on cycles t+1..t+8 with data H0..H7 in order.
   - write_complete is high on t+9 only; busy falls at t+10.
3. Backpressure: same digest, mem_ready toggling 1,0,0,1,0,1,... -> exactly 8 transfers, in order, with no skipped or duplicated word. Outputs are stable while ready=0, and write_complete pulses one cycle after the 8th accepted write.
4. Address wrap: base_address=0xFFFC -> addresses 0xFFFC,0xFFFD,0xFFFE,0xFFFF,0x0000,0x0001,0x0002,0x0003.
5. Ignored start: assert start with a different digest and base_address during WRITE and during DONE -> the original transaction completes unchanged, with no second transaction. A start at the first IDLE cycle afterwards launches a new transaction.
6. Reset mid-operation: assert reset after the 3rd accepted word -> mem_write_en=0 on the next cycle, no write_complete pulse, and the state is IDLE. A subsequent start writes all 8 words from word 0.

Source files
------------

// File: rtl/hash_output_writer.sv
// -----------------------------------------------------------------------------
// hash_output_writer
//
// Writes a finished SHA-256 digest (NUM_WORDS words, H0 first) to word-addressed
// memory, one word per accepted write. Memory backpressures with mem_ready.
// A one-cycle write_complete pulse follows acceptance of the last word.
//
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous, active-high reset
//   start          - request to write the digest (sampled only in IDLE)
//   base_address   - address of word 0, captured with start
//   digest         - H0 in the MSBs .. H(NUM_WORDS-1) in the LSBs, captured with start
//   mem_ready      - memory accepts the presented write this cycle
//   mem_write_en   - write request valid (registered)
//   mem_address    - write address (registered, wraps modulo 2^ADDR_WIDTH)
//   mem_write_data - write data (registered)
//   busy           - high in WRITE and DONE
//   write_complete - one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module hash_output_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_address,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0]  digest,
  input  logic                             mem_ready,
  output logic                             mem_write_en,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  output logic                             busy,
  output logic                             write_complete
);

  localparam int DIGEST_W = NUM_WORDS * DATA_WIDTH;
  // One extra bit so the index never overflows when it reaches the last word.
  localparam int IDX_W = $clog2(NUM_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  // Holding register: the word currently presented always sits in the MSBs.
  logic [DIGEST_W-1:0]     hold_r;
  logic [DIGEST_W-1:0]     hold_s;
  logic [DIGEST_W-1:0]     shifted_s;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        idx_s;
  logic                    write_en_s;
  logic [ADDR_WIDTH-1:0]   address_s;
  logic [DATA_WIDTH-1:0]   write_data_s;
  logic                    busy_s;
  logic                    complete_s;

  // State, holding register, word index and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      hold_r         <= {DIGEST_W{1'b0}};
      idx_r          <= {IDX_W{1'b0}};
      mem_write_en   <= 1'b0;
      mem_address    <= {ADDR_WIDTH{1'b0}};
      mem_write_data <= {DATA_WIDTH{1'b0}};
      busy           <= 1'b0;
      write_complete <= 1'b0;
    end else begin
      state_r        <= state_s;
      hold_r         <= hold_s;
      idx_r          <= idx_s;
      mem_write_en   <= write_en_s;
      mem_address    <= address_s;
      mem_write_data <= write_data_s;
      busy           <= busy_s;
      write_complete <= complete_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    hold_s       = hold_r;
    idx_s        = idx_r;
    write_en_s   = mem_write_en;
    address_s    = mem_address;
    write_data_s = mem_write_data;
    busy_s       = busy;
    complete_s   = 1'b0;
    shifted_s    = hold_r << DATA_WIDTH;

    case (state_r)
      IDLE: begin
        if (start) begin
          hold_s       = digest;
          idx_s        = {IDX_W{1'b0}};
          write_en_s   = 1'b1;
          address_s    = base_address;
          write_data_s = digest[DIGEST_W-1 -: DATA_WIDTH];
          busy_s       = 1'b1;
          state_s      = WRITE;
        end else begin
          // Address/data keep their last values; only the valid flags matter.
          write_en_s = 1'b0;
          busy_s     = 1'b0;
        end
      end

      WRITE: begin
        // mem_write_en is always high in WRITE, so mem_ready alone marks a transfer.
        if (mem_ready) begin
          if (idx_r == LAST_IDX) begin
            write_en_s = 1'b0;
            complete_s = 1'b1;
            busy_s     = 1'b1;
            state_s    = DONE;
          end else begin
            hold_s       = shifted_s;
            idx_s        = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            address_s    = mem_address + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            write_data_s = shifted_s[DIGEST_W-1 -: DATA_WIDTH];
            write_en_s   = 1'b1;
          end
        end else begin
          // Request stays raised and stable until memory takes it.
          write_en_s = 1'b1;
        end
      end

      DONE: begin
        write_en_s = 1'b0;
        busy_s     = 1'b0;
        state_s    = IDLE;
      end

      default: begin
        write_en_s = 1'b0;
        busy_s     = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hash_output_writer.sv
module tb_hash_output_writer;

  logic         clock;
  logic         reset;
  logic         start;
  logic [15:0]  base_address;
  logic [255:0] digest;
  logic         mem_ready;
  logic         mem_write_en;
  logic [15:0]  mem_address;
  logic [31:0]  mem_write_data;
  logic         busy;
  logic         write_complete;

  int n_checks = 0;
  int n_fail   = 0;

  hash_output_writer #(
    .DATA_WIDTH(32),
    .NUM_WORDS (8),
    .ADDR_WIDTH(16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_address  (base_address),
    .digest        (digest),
    .mem_ready     (mem_ready),
    .mem_write_en  (mem_write_en),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .busy          (busy),
    .write_complete(write_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]  base;
    logic [255:0] dig;
    int           mode;      // 0: ready always, 1: pattern 1,0,0,1,0,1 repeating, 2: random
    bit           hostile;   // drive start with junk during WRITE and DONE
    logic [15:0]  exp_last;  // expected address of word 7
    int           exp_cycles; // start edge to IDLE, -1 = not checked
  } vec_t;

  localparam logic [255:0] SHA_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [255:0] d, input int i);
    return d[255 - 32*i -: 32];
  endfunction

  function automatic logic pick_ready(input int mode, input int n);
    logic [5:0] pat;
    pat = 6'b101001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[(n - 1) % 6];
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one transaction starting from IDLE; checks every presented word against
  // the reference (base + k, k-th word of the digest) and the completion timing.
  task automatic run_txn(input logic [15:0] b, input logic [255:0] d, input int mode,
                         input bit hostile, input logic [15:0] exp_last, input int exp_cycles);
    int k;
    int n;
    logic rdy;
    logic [15:0] ea;
    start = 1'b1;
    base_address = b;
    digest = d;
    mem_ready = 1'b0;
    step();
    start = 1'b0;
    digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    base_address = 16'($urandom);
    k = 0;
    n = 1;
    while (k < 8 && n < 200) begin
      ea = b + 16'(k);
      chk("wr_en", 256'(mem_write_en), 256'(1'b1));
      chk("wr_addr", 256'(mem_address), 256'(ea));
      chk("wr_data", 256'(mem_write_data), 256'(model_word(d, k)));
      chk("busy_wr", 256'(busy), 256'(1'b1));
      chk("wc_early", 256'(write_complete), 256'(1'b0));
      rdy = pick_ready(mode, n);
      mem_ready = rdy;
      if (hostile) begin
        start = 1'($urandom_range(0, 1));
        base_address = 16'($urandom);
        digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (rdy) begin
        if (k == 7) chk("last_addr", 256'(mem_address), 256'(exp_last));
        k++;
      end
      step();
      n++;
    end
    chk("timeout_words", 256'(k), 256'(8));
    start = 1'b0;
    chk("done_en", 256'(mem_write_en), 256'(1'b0));
    chk("done_wc", 256'(write_complete), 256'(1'b1));
    chk("done_busy", 256'(busy), 256'(1'b1));
    mem_ready = 1'($urandom_range(0, 1));
    if (hostile) begin
      start = 1'b1;
      base_address = 16'($urandom);
    end
    step();
    n++;
    start = 1'b0;
    chk("idle_en", 256'(mem_write_en), 256'(1'b0));
    chk("idle_wc", 256'(write_complete), 256'(1'b0));
    chk("idle_busy", 256'(busy), 256'(1'b0));
    if (exp_cycles >= 0) chk("latency", 256'(n), 256'(exp_cycles));
  endtask

  vec_t vecs[5];

  initial begin
    logic [15:0]  rb;
    logic [255:0] rd;

    vecs[0] = '{16'h0100, SHA_INIT, 0, 1'b0, 16'h0107, 10};
    vecs[1] = '{16'h0100, SHA_INIT, 1, 1'b0, 16'h0107, 18};
    vecs[2] = '{16'hFFFC, 256'h01234567_89abcdef_fedcba98_76543210_deadbeef_cafef00d_0badc0de_feedface,
                0, 1'b0, 16'h0003, 10};
    vecs[3] = '{16'h1234, ~SHA_INIT, 0, 1'b1, 16'h123B, 10};
    vecs[4] = '{16'h0000, SHA_INIT ^ 256'h5, 1, 1'b1, 16'h0007, 18};

    // Reset with random inputs, start held high.
    reset = 1'b1;
    start = 1'b1;
    mem_ready = 1'b1;
    base_address = 16'($urandom);
    digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ready = 1'($urandom_range(0, 1));
      base_address = 16'($urandom);
      chk("rst_en", 256'(mem_write_en), 256'(1'b0));
      chk("rst_addr", 256'(mem_address), 256'(16'h0));
      chk("rst_data", 256'(mem_write_data), 256'(32'h0));
      chk("rst_busy", 256'(busy), 256'(1'b0));
      chk("rst_wc", 256'(write_complete), 256'(1'b0));
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("post_rst_en", 256'(mem_write_en), 256'(1'b0));
    chk("post_rst_busy", 256'(busy), 256'(1'b0));

    // Table-driven transactions.
    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].base, vecs[v].dig, vecs[v].mode, vecs[v].hostile,
              vecs[v].exp_last, vecs[v].exp_cycles);
    end

    // Reset after the third accepted word aborts the transaction.
    start = 1'b1;
    base_address = 16'h2000;
    digest = SHA_INIT;
    mem_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("abort_addr_pre", 256'(mem_address), 256'(16'h2003));
    reset = 1'b1;
    mem_ready = 1'b0;
    step();
    reset = 1'b0;
    chk("abort_en", 256'(mem_write_en), 256'(1'b0));
    chk("abort_busy", 256'(busy), 256'(1'b0));
    chk("abort_wc", 256'(write_complete), 256'(1'b0));
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      step();
      chk("abort_quiet_en", 256'(mem_write_en), 256'(1'b0));
      chk("abort_quiet_wc", 256'(write_complete), 256'(1'b0));
    end
    run_txn(16'h2000, SHA_INIT, 0, 1'b0, 16'h2007, 10);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 20; t++) begin
      rb = 16'($urandom);
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(rb, rd, 2, 1'($urandom_range(0, 1)), rb + 16'd7, -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step();
        chk("gap_en", 256'(mem_write_en), 256'(1'b0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
